// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, register-select type and decode/byte-lane helpers for gpio_regfile.
package gpio_pkg;

    localparam logic [7:0] GPIO_DATA_OUT_OFS   = 8'h00;
    localparam logic [7:0] GPIO_DIR_OFS        = 8'h04;
    localparam logic [7:0] GPIO_DATA_IN_OFS    = 8'h08;
    localparam logic [7:0] GPIO_INT_EN_OFS     = 8'h0C;
    localparam logic [7:0] GPIO_INT_TYPE_OFS   = 8'h10;
    localparam logic [7:0] GPIO_INT_POL_OFS    = 8'h14;
    localparam logic [7:0] GPIO_INT_STATUS_OFS = 8'h18;

    typedef enum logic [2:0] {
        RegDataOut,
        RegDir,
        RegDataIn,
        RegIntEn,
        RegIntType,
        RegIntPol,
        RegIntStatus,
        RegNone
    } gpio_reg_e;

    // Interrupt offsets only decode when the interrupt block is built in.
    function automatic gpio_reg_e decode_reg(input logic [7:0] ofs, input logic has_int);
        gpio_reg_e sel;
        sel = RegNone;
        case (ofs)
            GPIO_DATA_OUT_OFS:   sel = RegDataOut;
            GPIO_DIR_OFS:        sel = RegDir;
            GPIO_DATA_IN_OFS:    sel = RegDataIn;
            GPIO_INT_EN_OFS:     if (has_int) sel = RegIntEn;
            GPIO_INT_TYPE_OFS:   if (has_int) sel = RegIntType;
            GPIO_INT_POL_OFS:    if (has_int) sel = RegIntPol;
            GPIO_INT_STATUS_OFS: if (has_int) sel = RegIntStatus;
            default:             sel = RegNone;
        endcase
        return sel;
    endfunction

    function automatic logic [7:0] lane_mask(input logic en);
        return {8{en}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: parameterized-width two-flop synchronizer with asynchronous active-low reset.
module gpio_sync #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gpio_regfile.sv
// gpio_regfile: GPIO register bank, pad drive, input synchronizer and interrupt logic.
// Interrupt registers, edge/level detection and irq exist only when GPIO_INT_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module gpio_regfile
    import gpio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    gpio_wr_en,
    input  logic                    gpio_rd_en,
    input  logic [ADDR_WIDTH-1:0]   gpio_reg_addr,
    input  logic [DATA_WIDTH-1:0]   gpio_wdata,
    input  logic [DATA_WIDTH/8-1:0] gpio_strb,
    output logic [DATA_WIDTH-1:0]   gpio_rdata,
    output logic                    gpio_error,
    input  logic [DATA_WIDTH-1:0]   gpio_in,
    output logic [DATA_WIDTH-1:0]   gpio_out,
    output logic [DATA_WIDTH-1:0]   gpio_oe,
    output logic                    irq
);

`ifdef GPIO_INT_EN
    localparam logic HasInt = 1'b1;
`else
    localparam logic HasInt = 1'b0;
`endif
    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    logic [7:0]            ofs;
    gpio_reg_e             sel;
    logic                  bad_access;
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] bmask;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] dir_q;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_addr;

    assign ofs         = gpio_reg_addr[7:0];
    assign unused_addr = ^gpio_reg_addr[ADDR_WIDTH-1:8];
    assign sel         = decode_reg(ofs, HasInt);

    // A simultaneous read+write is a write, so DATA_IN must also reject it.
    assign bad_access = (ofs[1:0] != 2'b00) || (sel == RegNone) ||
                        (gpio_wr_en && (sel == RegDataIn));
    assign gpio_error = (gpio_wr_en | gpio_rd_en) & bad_access;
    assign wr_ok      = gpio_wr_en & ~bad_access;

    for (genvar b = 0; b < NumBytes; b++) begin : g_bmask
        assign bmask[8*b +: 8] = lane_mask(gpio_strb[b]);
    end

    gpio_sync #(
        .WIDTH (DATA_WIDTH)
    ) u_sync (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .d     (gpio_in),
        .q     (data_in)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out_q <= '0;
            dir_q      <= '0;
        end else if (wr_ok) begin
            if (sel == RegDataOut) data_out_q <= (data_out_q & ~bmask) | (gpio_wdata & bmask);
            if (sel == RegDir)     dir_q      <= (dir_q & ~bmask) | (gpio_wdata & bmask);
        end
    end

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;

`ifdef GPIO_INT_EN
    logic [DATA_WIDTH-1:0] int_en_q;
    logic [DATA_WIDTH-1:0] int_type_q;
    logic [DATA_WIDTH-1:0] int_pol_q;
    logic [DATA_WIDTH-1:0] int_status_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] raw_set;
    logic [DATA_WIDTH-1:0] w1c;

    always_comb begin
        raw_set = (int_type_q & ((int_pol_q & data_in & ~prev_q) |
                                 (~int_pol_q & ~data_in & prev_q))) |
                  (~int_type_q & ~(data_in ^ int_pol_q));
    end

    assign w1c = (wr_ok && (sel == RegIntStatus)) ? (gpio_wdata & bmask) : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            int_en_q     <= '0;
            int_type_q   <= '0;
            int_pol_q    <= '0;
            int_status_q <= '0;
            prev_q       <= '0;
        end else begin
            prev_q       <= data_in;
            // Set has priority over a same-cycle W1C of the same bit.
            int_status_q <= (int_status_q & ~w1c) | raw_set;
            if (wr_ok) begin
                if (sel == RegIntEn)   int_en_q   <= (int_en_q & ~bmask) | (gpio_wdata & bmask);
                if (sel == RegIntType) int_type_q <= (int_type_q & ~bmask) | (gpio_wdata & bmask);
                if (sel == RegIntPol)  int_pol_q  <= (int_pol_q & ~bmask) | (gpio_wdata & bmask);
            end
        end
    end

    assign irq = |(int_status_q & int_en_q);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (sel)
            RegDataOut:   rd_val = data_out_q;
            RegDir:       rd_val = dir_q;
            RegDataIn:    rd_val = data_in;
`ifdef GPIO_INT_EN
            RegIntEn:     rd_val = int_en_q;
            RegIntType:   rd_val = int_type_q;
            RegIntPol:    rd_val = int_pol_q;
            RegIntStatus: rd_val = int_status_q;
`endif
            default:      rd_val = '0;
        endcase
    end

    assign gpio_rdata = (gpio_rd_en && !bad_access) ? rd_val : '0;

endmodule
